// File: rtl/vga_timing_pkg.sv
// Shared 800x600@60 timing constants, counter type and colour-bar table.
// Used by vga_timing, vga_test_pattern and the downstream mux/draw blocks.
package vga_timing_pkg;

  localparam int CNT_W = 11;

  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = 1056;

  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = 628;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h;
    cnt_t v;
    logic hsync;
    logic hblnk;
    logic vsync;
    logic vblnk;
    logic fstart;
  } vga_t;

  function automatic logic [11:0] bar_color(input logic [2:0] idx);
    logic [11:0] c;
    c = 12'h000;
    unique case (idx)
      3'd0: c = 12'hFFF;
      3'd1: c = 12'hFF0;
      3'd2: c = 12'h0FF;
      3'd3: c = 12'h0F0;
      3'd4: c = 12'hF0F;
      3'd5: c = 12'hF00;
      3'd6: c = 12'h00F;
      3'd7: c = 12'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_test_pattern.sv
// Eight 100-pixel vertical colour bars, black while blanked (combinational).
// Ports: hpos (hcount[9:0]), blank, rgb (4:4:4).
module vga_test_pattern
  import vga_timing_pkg::*;
(
  input  logic [9:0]  hpos,
  input  logic        blank,
  output logic [11:0] rgb
);

  logic [2:0] idx;

  always_comb begin
    idx = 3'(hpos / 10'd100);
    rgb = blank ? 12'h000 : bar_color(idx);
  end

endmodule

// File: rtl/vga_timing.sv
// 800x600@60 VGA timing generator with registered, zero-skew sync/blank flags.
// Ports: clk, rst (sync, low), en, h/v counts, syncs, blanks, frame_start;
// rgb_out exists only with VGA_TIMING_TEST_PATTERN_EN defined.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VIS_P = H_VISIBLE,
  parameter int H_FP_P  = H_FRONT,
  parameter int H_SW_P  = H_SYNC,
  parameter int H_BP_P  = H_BACK,
  parameter int V_VIS_P = V_VISIBLE,
  parameter int V_FP_P  = V_FRONT,
  parameter int V_SW_P  = V_SYNC,
  parameter int V_BP_P  = V_BACK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] hcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic             frame_start
`ifdef VGA_TIMING_TEST_PATTERN_EN
  ,
  output logic [11:0]      rgb_out
`endif
);

  localparam cnt_t H_LAST = cnt_t'(H_VIS_P + H_FP_P + H_SW_P + H_BP_P - 1);
  localparam cnt_t H_SS   = cnt_t'(H_VIS_P + H_FP_P);
  localparam cnt_t H_SE   = cnt_t'(H_VIS_P + H_FP_P + H_SW_P - 1);
  localparam cnt_t H_BS   = cnt_t'(H_VIS_P);

  localparam cnt_t V_LAST = cnt_t'(V_VIS_P + V_FP_P + V_SW_P + V_BP_P - 1);
  localparam cnt_t V_SS   = cnt_t'(V_VIS_P + V_FP_P);
  localparam cnt_t V_SE   = cnt_t'(V_VIS_P + V_FP_P + V_SW_P - 1);
  localparam cnt_t V_BS   = cnt_t'(V_VIS_P);

  vga_t cur_q;
  vga_t cur_d;
  cnt_t h_nxt;
  cnt_t v_nxt;
  logic hb_nxt;
  logic vb_nxt;

  // Advanced counts; flags decode these so they line up with the
  // counter value registered in the same edge.
  always_comb begin
    h_nxt = cur_q.h + cnt_t'(1);
    v_nxt = cur_q.v;
    if (cur_q.h == H_LAST) begin
      h_nxt = '0;
      v_nxt = (cur_q.v == V_LAST) ? '0 : cur_q.v + cnt_t'(1);
    end
    hb_nxt = (h_nxt >= H_BS);
    vb_nxt = (v_nxt >= V_BS);
  end

  always_comb begin
    cur_d        = cur_q;
    cur_d.fstart = 1'b0;
    if (en) begin
      cur_d.h      = h_nxt;
      cur_d.v      = v_nxt;
      cur_d.hblnk  = hb_nxt;
      cur_d.vblnk  = vb_nxt;
      cur_d.hsync  = (h_nxt >= H_SS) && (h_nxt <= H_SE);
      cur_d.vsync  = (v_nxt >= V_SS) && (v_nxt <= V_SE);
      cur_d.fstart = (h_nxt == '0) && (v_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cur_q <= '0;
    else      cur_q <= cur_d;
  end

  assign hcount_out  = cur_q.h;
  assign vcount_out  = cur_q.v;
  assign hsync_out   = cur_q.hsync;
  assign hblnk_out   = cur_q.hblnk;
  assign vsync_out   = cur_q.vsync;
  assign vblnk_out   = cur_q.vblnk;
  assign frame_start = cur_q.fstart;

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [11:0] rgb_nxt;
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;

  vga_test_pattern u_pat (
    .hpos  (h_nxt[9:0]),
    .blank (hb_nxt | vb_nxt),
    .rgb   (rgb_nxt)
  );

  always_comb begin
    rgb_d = rgb_q;
    if (en) rgb_d = rgb_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) rgb_q <= '0;
    else      rgb_q <= rgb_d;
  end

  assign rgb_out = rgb_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Randomised-enable check of vga_timing against a pixel-index model.
// Instance b shortens the vertical field so whole frames fit in the run.
module tb_vga_timing;

  localparam int HT  = 1056;
  localparam int AVV = 600;
  localparam int AVT = 628;
  localparam int BVV = 6;
  localparam int BVT = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic [10:0] a_h, a_v, b_h, b_v;
  logic a_hs, a_hb, a_vs, a_vb, a_fs;
  logic b_hs, b_hb, b_vs, b_vb, b_fs;
  logic [26:0] vec_a, vec_b;

  assign vec_a = {a_h, a_v, a_hs, a_hb, a_vs, a_vb, a_fs};
  assign vec_b = {b_h, b_v, b_hs, b_hb, b_vs, b_vb, b_fs};

`ifdef VGA_TIMING_TEST_PATTERN_EN
  logic [11:0] a_rgb, b_rgb;
`endif

  vga_timing u_a (
    .clk (clk), .rst (rst), .en (en),
    .hcount_out (a_h), .hsync_out (a_hs), .hblnk_out (a_hb),
    .vcount_out (a_v), .vsync_out (a_vs), .vblnk_out (a_vb),
    .frame_start (a_fs)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .rgb_out (a_rgb)
`endif
  );

  vga_timing #(.V_VIS_P (6), .V_BP_P (3)) u_b (
    .clk (clk), .rst (rst), .en (en),
    .hcount_out (b_h), .hsync_out (b_hs), .hblnk_out (b_hb),
    .vcount_out (b_v), .vsync_out (b_vs), .vblnk_out (b_vb),
    .frame_start (b_fs)
`ifdef VGA_TIMING_TEST_PATTERN_EN
    , .rgb_out (b_rgb)
`endif
  );

  int total = 0;
  int bad = 0;
  longint n = 0;
  bit adv = 1'b0;
  logic [11:0] er_a = '0;
  logic [11:0] er_b = '0;

  // n = enabled edges since reset; everything follows from it.
  function automatic logic [26:0] model(input longint k, input int vv,
                                        input int vt, input bit a);
    int h, v;
    logic hs, hb, vs, vb, fs;
    h  = int'(k % HT);
    v  = int'((k / HT) % vt);
    hb = (h >= 800);
    hs = (h >= 840) && (h <= 967);
    vb = (v >= vv);
    vs = (v >= vv + 1) && (v <= vv + 4);
    fs = a && ((k % (longint'(HT) * vt)) == 0);
    return {11'(h), 11'(v), hs, hb, vs, vb, fs};
  endfunction

  function automatic logic [11:0] bar(input longint k, input int vv,
                                      input int vt);
    int h, v;
    h = int'(k % HT);
    v = int'((k / HT) % vt);
    if (h >= 800 || v >= vv) return 12'h000;
    case (h / 100)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  task automatic step(input bit r, input bit e);
    rst = r;
    en  = e;
    @(posedge clk);
    #1;
    if (!r) begin
      n = 0; adv = 1'b0; er_a = '0; er_b = '0;
    end else if (e) begin
      n++; adv = 1'b1;
      er_a = bar(n, AVV, AVT);
      er_b = bar(n, BVV, BVT);
    end else begin
      adv = 1'b0;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'($urandom_range(0, 1)));
      total++;
      if (vec_a !== 27'd0 || vec_b !== 27'd0) begin
        bad++;
        $display("FAIL reset got a=%h b=%h want 0", vec_a, vec_b);
      end
`ifdef VGA_TIMING_TEST_PATTERN_EN
      total++;
      if (a_rgb !== 12'h000) begin
        bad++;
        $display("FAIL reset_rgb got %h want 000", a_rgb);
      end
`endif
    end
  endtask

  task automatic test_first();
    step(1'b1, 1'b1);
    total++;
    if (a_h !== 11'd1 || a_v !== 11'd0 || b_h !== 11'd1) begin
      bad++;
      $display("FAIL first got h=%0d v=%0d want 1 0", a_h, a_v);
    end
  endtask

  task automatic test_count();
    longint target;
    int fs_cnt;
    bit e;
    target = 2 * longint'(HT) * BVT + 7;
    fs_cnt = 0;
    for (int i = 0; i < 60000 && n < target; i++) begin
      e = ($urandom_range(0, 7) != 0);
      step(1'b1, e);
      total++;
      if (vec_a !== model(n, AVV, AVT, adv)) begin
        bad++;
        $display("FAIL count_a n=%0d got %h want %h",
                 n, vec_a, model(n, AVV, AVT, adv));
      end
      total++;
      if (vec_b !== model(n, BVV, BVT, adv)) begin
        bad++;
        $display("FAIL count_b n=%0d got %h want %h",
                 n, vec_b, model(n, BVV, BVT, adv));
      end
`ifdef VGA_TIMING_TEST_PATTERN_EN
      total++;
      if (a_rgb !== er_a || b_rgb !== er_b) begin
        bad++;
        $display("FAIL rgb n=%0d got %h/%h want %h/%h",
                 n, a_rgb, b_rgb, er_a, er_b);
      end
`endif
      if (b_fs === 1'b1) fs_cnt++;
    end
    total++;
    if (n < target) begin
      bad++;
      $display("FAIL count_timeout got n=%0d want %0d", n, target);
    end
    total++;
    if (fs_cnt !== 2) begin
      bad++;
      $display("FAIL frame_pulses got %0d want 2", fs_cnt);
    end
  endtask

  task automatic test_hold();
    logic [26:0] saved;
    for (int i = 0; i < 2000 && (n % HT) != 500; i++) step(1'b1, 1'b1);
    total++;
    if (a_h !== 11'd500 || vec_a !== model(n, AVV, AVT, adv)) begin
      bad++;
      $display("FAIL hold_reach got h=%0d want 500", a_h);
    end
    saved = vec_a;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b0);
      total++;
      if (vec_a !== {saved[26:1], 1'b0}) begin
        bad++;
        $display("FAIL hold got %h want %h", vec_a, {saved[26:1], 1'b0});
      end
`ifdef VGA_TIMING_TEST_PATTERN_EN
      total++;
      if (a_rgb !== er_a) begin
        bad++;
        $display("FAIL hold_rgb got %h want %h", a_rgb, er_a);
      end
`endif
    end
    step(1'b1, 1'b1);
    total++;
    if (a_h !== 11'd501) begin
      bad++;
      $display("FAIL hold_resume got %0d want 501", a_h);
    end
  endtask

  task automatic test_midreset();
    for (int i = 0; i < 2000 && (n % HT) != 900; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    total++;
    if (a_h !== 11'd900) begin
      bad++;
      $display("FAIL mid_reach got %0d want 900", a_h);
    end
    step(1'b0, 1'b0);
    total++;
    if (vec_a !== 27'd0 || vec_b !== 27'd0) begin
      bad++;
      $display("FAIL mid_reset got a=%h b=%h want 0", vec_a, vec_b);
    end
`ifdef VGA_TIMING_TEST_PATTERN_EN
    total++;
    if (a_rgb !== 12'h000) begin
      bad++;
      $display("FAIL mid_reset_rgb got %h want 000", a_rgb);
    end
`endif
    step(1'b1, 1'b1);
    total++;
    if (a_h !== 11'd1 || a_v !== 11'd0 ||
        vec_a !== model(n, AVV, AVT, adv)) begin
      bad++;
      $display("FAIL mid_restart got h=%0d v=%0d want 1 0", a_h, a_v);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_count();
    test_hold();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
